// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller: register width,
// forwarding-select encodings and the shadow stage records.
package pipeline_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Write-side record carried by every shadow stage.
    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic              wren;
        logic              load;
    } wr_info_t;

    // EX shadow stage additionally keeps its source registers for forwarding.
    typedef struct packed {
        wr_info_t          wr;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } ex_info_t;

    function automatic logic is_writer(input logic vld, input logic wren,
                                       input logic [REG_AW-1:0] dest);
        return vld && wren && (dest != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one EX operand: the youngest matching writer wins,
// MEM before WB, falling back to the register file.
module hazard_fwd_unit #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              mem_fwd,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              wb_fwd,
    input  logic [REG_AW-1:0] wb_dest,
    output logic [1:0]        sel
);
    import pipeline_pkg::*;

    always_comb begin
        sel = FWD_RF;
        if (mem_fwd && (mem_dest == src))
            sel = FWD_MEM;
        else if (wb_fwd && (wb_dest == src))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EX/MEM/WB pipeline: stage enables,
// flushes, load-use bubbles, memory-wait freeze and EX operand forwarding.
module pipeline_hazard_ctrl #(
    parameter int REG_AW   = pipeline_pkg::REG_AW,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_RF_WrEn,
    input  logic              id_is_load,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_count
);
    import pipeline_pkg::*;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic              vld_p0, vld_p1, vld_p2;
    ex_info_t          ex_p0;
    wr_info_t          wr_p1;
    logic [REG_AW-1:0] dest_p2;
    logic              wren_p2;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ex_load_wr, load_use, bubble, mem_fwd, wb_fwd;

    assign ex_load_wr = is_writer(vld_p0, ex_p0.wr.wren, ex_p0.wr.dest) && ex_p0.wr.load;
    assign load_use   = id_valid && ex_load_wr &&
                        ((id_rs == ex_p0.wr.dest) || (id_uses_rt && (id_rt == ex_p0.wr.dest)));
    assign bubble     = branch_taken || load_use;
    // A load still in MEM has no data yet, so it must not forward.
    assign mem_fwd    = is_writer(vld_p1, wr_p1.wren, wr_p1.dest) && !wr_p1.load;
    assign wb_fwd     = is_writer(vld_p2, wren_p2, dest_p2);

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Stage boundary ID -> EX -> MEM -> WB: valids
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (!mem_busy) begin
            vld_p2 <= vld_p1;
            vld_p1 <= vld_p0;
            vld_p0 <= id_valid && !bubble;
        end
    end

    // Stage boundary ID -> EX -> MEM -> WB: payload
    always_ff @(posedge Clk) begin
        if (!mem_busy) begin
            dest_p2 <= wr_p1.dest;
            wren_p2 <= wr_p1.wren;
            wr_p1   <= ex_p0.wr;
            if (bubble)
                ex_p0 <= '0;
            else
                ex_p0 <= '{wr: '{dest: id_dest, wren: id_RF_WrEn, load: id_is_load},
                           rs: id_rs, rt: id_rt};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            if (!mem_busy)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_W'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;
            if (mem_busy && (wait_cnt == WAIT_W'(MAX_WAIT - 1)))
                mem_timeout <= 1'b1;
            if (!pc_en)
                stall_count <= sat_inc(stall_count);
        end
    end

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src      (ex_p0.rs),
        .mem_fwd  (mem_fwd),
        .mem_dest (wr_p1.dest),
        .wb_fwd   (wb_fwd),
        .wb_dest  (dest_p2),
        .sel      (fwd_a_sel)
    );

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src      (ex_p0.rt),
        .mem_fwd  (mem_fwd),
        .mem_dest (wr_p1.dest),
        .wb_fwd   (wb_fwd),
        .wb_dest  (dest_p2),
        .sel      (fwd_b_sel)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random traffic,
// all checked against a stage-list reference model.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             id_valid, id_uses_rt, id_RF_WrEn, id_is_load, branch_taken, mem_busy;
    logic [4:0]       id_rs, id_rt, id_dest;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl #(.REG_AW(5), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_RF_WrEn(id_RF_WrEn), .id_is_load(id_is_load),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    // Reference model: st[0] = EX, st[1] = MEM, st[2] = WB
    typedef struct {
        bit vld;
        int dest;
        bit wren;
        bit load;
        int rs;
        int rt;
    } mstg_t;

    mstg_t st[3];
    int    consec;
    bit    m_timeout;
    int    m_stall;
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit writer(input mstg_t s);
        return s.vld && s.wren && (s.dest != 0);
    endfunction

    function automatic int mfwd(input int src);
        if (writer(st[1]) && !st[1].load && st[1].dest == src) return 1;
        if (writer(st[2]) && st[2].dest == src) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) st[i] = '{default: 0};
        consec    = 0;
        m_timeout = 0;
        m_stall   = 0;
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_pc_en"}, pc_en, 1);
        chk({pfx, "_ifid_en"}, ifid_en, 1);
        chk({pfx, "_idex_en"}, idex_en, 1);
        chk({pfx, "_exmem_en"}, exmem_en, 1);
        chk({pfx, "_memwb_en"}, memwb_en, 1);
        chk({pfx, "_flushes"}, {ifid_flush, idex_flush}, 0);
        chk({pfx, "_fwd"}, {fwd_a_sel, fwd_b_sel}, 0);
        chk({pfx, "_stall_count"}, stall_count, 0);
        chk({pfx, "_timeout"}, mem_timeout, 0);
    endtask

    // One pipeline cycle: drive ID/hazard inputs, check outputs, advance the model.
    task automatic step(input bit v, input int rs, input int rt, input bit urt, input int dest,
                        input bit wr, input bit ld, input bit br, input bit busy);
        bit lu, lb, fl;
        @(negedge Clk);
        id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_uses_rt = urt;
        id_dest = dest[4:0]; id_RF_WrEn = wr; id_is_load = ld;
        branch_taken = br; mem_busy = busy;
        #1;
        lu = v && writer(st[0]) && st[0].load &&
             (rs == st[0].dest || (urt && rt == st[0].dest));
        fl = !busy && br;
        lb = !busy && !br && lu;
        chk("pc_en", pc_en, !busy && !lb);
        chk("ifid_en", ifid_en, !busy && !lb);
        chk("ifid_flush", ifid_flush, fl);
        chk("idex_en", idex_en, !busy);
        chk("idex_flush", idex_flush, fl || lb);
        chk("exmem_en", exmem_en, !busy);
        chk("memwb_en", memwb_en, !busy);
        chk("fwd_a_sel", fwd_a_sel, mfwd(st[0].rs));
        chk("fwd_b_sel", fwd_b_sel, mfwd(st[0].rt));
        chk("mem_timeout", mem_timeout, m_timeout);
        chk("stall_count", stall_count, m_stall);
        @(posedge Clk);
        if (busy) begin
            consec++;
            if (consec >= MAX_WAIT) m_timeout = 1;
            if (m_stall < CNT_MAX) m_stall++;
        end else begin
            consec = 0;
            if (lb && m_stall < CNT_MAX) m_stall++;
            st[2] = st[1];
            st[1] = st[0];
            if (fl || lb) st[0] = '{default: 0};
            else          st[0] = '{v, dest, wr, ld, rs, rt};
        end
    endtask

    task automatic do_reset(input string pfx);
        @(negedge Clk);
        #2;
        mem_busy = 0; branch_taken = 0; id_valid = 0;
        Reset = 1;
        #1;
        model_reset();
        chk_idle(pfx);
        @(negedge Clk);
        Reset = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        bit busy_r;
        Reset = 1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_dest = 0;
        id_RF_WrEn = 0; id_is_load = 0; branch_taken = 0; mem_busy = 0;
        model_reset();
        repeat (2) @(negedge Clk);
        chk_idle("reset");
        Reset = 0;

        // Reset pulsed in the middle of a freeze
        repeat (5) step(1, 1, 2, 1, 3, 1, 0, 0, 1);
        do_reset("midfreeze");

        // add $3 ; sub $4,$3,$1 ; and $6,$3,$2
        step(1, 1, 2, 1, 3, 1, 0, 0, 0);
        step(1, 3, 1, 1, 4, 1, 0, 0, 0);
        #1 chk("t2_fwd_mem", fwd_a_sel, 2'b01);
        step(1, 3, 2, 1, 6, 1, 0, 0, 0);
        #1 chk("t2_fwd_wb", fwd_a_sel, 2'b10);

        // lw $5 followed by a reader of rt = $5
        step(1, 1, 0, 0, 5, 1, 1, 0, 0);
        step(1, 7, 5, 1, 8, 1, 0, 0, 0);
        #1 chk("t3_one_bubble", pc_en, 1);
        step(1, 7, 5, 1, 8, 1, 0, 0, 0);
        #1 chk("t3_fwd_wb", fwd_b_sel, 2'b10);

        // lw $0 followed by a reader of $0
        step(1, 1, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 10, 1, 0, 0, 0);
        #1 chk("t4_fwd_zero", {fwd_a_sel, fwd_b_sel}, 0);
        chk("t4_no_stall", stall_count, 1);

        // branch taken coinciding with a load-use
        step(1, 1, 0, 0, 6, 1, 1, 0, 0);
        step(1, 6, 0, 0, 9, 1, 0, 1, 0);
        #1 chk("t5_stall_unchanged", stall_count, 1);

        // 16-cycle memory freeze with a populated pipeline
        do_reset("pre_freeze");
        step(1, 2, 3, 1, 1, 1, 0, 0, 0);
        step(1, 1, 4, 1, 2, 1, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(1, 1, 2, 1, 9, 1, 0, 1, 1);
            #1;
            if (i == 14) chk("t6_timeout_14", mem_timeout, 0);
            if (i == 15) chk("t6_timeout_15", mem_timeout, 1);
        end
        chk("t6_stall_16", stall_count, 16);
        chk("t6_shadow_held", fwd_a_sel, 2'b01);
        step(1, 2, 1, 1, 9, 1, 0, 0, 0);
        #1 chk("t6_timeout_sticky", mem_timeout, 1);

        // Random traffic over a small register set to provoke hazards
        do_reset("pre_random");
        burst = 0;
        for (int n = 0; n < 500; n++) begin
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = 17;
            busy_r = (burst > 0) || ($urandom_range(0, 9) == 0);
            if (burst > 0) burst--;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, busy_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
